// File: rtl/eaglesong_sponge_ctrl.sv
// Eaglesong sponge controller: absorbs 256-bit rate blocks into the 512-bit state, runs one
// permutation per block through an external core and presents the 256-bit digest afterwards.
module eaglesong_sponge_ctrl #(
    parameter int PERM_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              abort,
    input  logic              block_valid,
    output logic              block_ready,
    input  logic [255:0]      block_data,
    input  logic              block_last,
    output logic [15:0][31:0] perm_state_input,
    output logic              perm_start,
    input  logic [15:0][31:0] perm_state_output,
    input  logic              perm_done,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic [255:0]      digest,
    output logic              busy,
    output logic              error,
    output logic [CNT_W-1:0]  block_count,
    output logic [2:0]        dbg_state
);

    localparam int TMR_W = $clog2(PERM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PERM_START = 3'd1,
        S_PERM_WAIT  = 3'd2,
        S_DIGEST     = 3'd3,
        S_ERROR      = 3'd4
    } state_e;

    state_e             fsm_q;
    logic [15:0][31:0]  state_q;
    logic [15:0][31:0]  absorb_d;
    logic [CNT_W-1:0]   block_count_q;
    logic [CNT_W-1:0]   block_count_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               block_ready_q;
    logic               perm_start_q;
    logic               error_q;
    logic               last_q;

    // Rate words 0..7 take the block XOR; capacity words 8..15 pass through untouched.
    always_comb begin
        absorb_d = state_q;
        for (int i = 0; i < 8; i++) begin
            absorb_d[i] = state_q[i] ^ block_data[255 - 32*i -: 32];
        end
    end

    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            digest[255 - 32*i -: 32] = state_q[i];
        end
    end

    assign block_count_d = (&block_count_q) ? block_count_q : block_count_q + CNT_W'(1);
    assign timer_d       = timer_q + TMR_W'(1);

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // ready never depends combinationally on valid, and the producer holds data while unaccepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q         <= S_IDLE;
            state_q       <= '0;
            block_count_q <= '0;
            timer_q       <= '0;
            block_ready_q <= 1'b0;
            perm_start_q  <= 1'b0;
            error_q       <= 1'b0;
            last_q        <= 1'b0;
        end else if (abort) begin
            fsm_q         <= S_IDLE;
            state_q       <= '0;
            block_count_q <= '0;
            timer_q       <= '0;
            block_ready_q <= 1'b1;
            perm_start_q  <= 1'b0;
            error_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    block_ready_q <= 1'b1;
                    if (block_valid && block_ready_q) begin
                        state_q       <= absorb_d;
                        last_q        <= block_last;
                        block_count_q <= block_count_d;
                        block_ready_q <= 1'b0;
                        perm_start_q  <= 1'b1;
                        fsm_q         <= S_PERM_START;
                    end
                end
                S_PERM_START: begin
                    timer_q <= '0;
                    fsm_q   <= S_PERM_WAIT;
                end
                S_PERM_WAIT: begin
                    // A done arriving on the timeout edge still wins.
                    if (perm_done) begin
                        state_q <= perm_state_output;
                        if (last_q) begin
                            fsm_q <= S_DIGEST;
                        end else begin
                            fsm_q         <= S_IDLE;
                            block_ready_q <= 1'b1;
                        end
                    end else if (timer_q == TMR_W'(PERM_TIMEOUT - 2)) begin
                        error_q <= 1'b1;
                        fsm_q   <= S_ERROR;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                S_DIGEST: begin
                    if (digest_ready) begin
                        state_q       <= '0;
                        block_count_q <= '0;
                        block_ready_q <= 1'b1;
                        fsm_q         <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    block_ready_q <= 1'b0;
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign block_ready      = block_ready_q;
    assign perm_start       = perm_start_q;
    assign perm_state_input = state_q;
    assign digest_valid     = (fsm_q == S_DIGEST);
    assign busy             = (fsm_q != S_IDLE);
    assign error            = error_q;
    assign block_count      = block_count_q;
    assign dbg_state        = fsm_q;

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Bench for eaglesong_sponge_ctrl: stub permutation (each word ^ A5A5A5A5), a vector table,
// directed multi-cycle corners and random messages against a word-level sponge model.
`timescale 1ns/1ps
module tb_eaglesong_sponge_ctrl;
    localparam int          PERM_TIMEOUT = 64;
    localparam int          CNT_W        = 16;
    localparam logic [31:0] MASK         = 32'hA5A5A5A5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              abort;
    logic              block_valid;
    logic              block_ready;
    logic [255:0]      block_data;
    logic              block_last;
    logic [15:0][31:0] perm_state_input;
    logic              perm_start;
    logic [15:0][31:0] perm_state_output;
    logic              perm_done;
    logic              digest_valid;
    logic              digest_ready;
    logic [255:0]      digest;
    logic              busy;
    logic              error;
    logic [CNT_W-1:0]  block_count;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    eaglesong_sponge_ctrl #(.PERM_TIMEOUT(PERM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .abort(abort),
        .block_valid(block_valid), .block_ready(block_ready),
        .block_data(block_data), .block_last(block_last),
        .perm_state_input(perm_state_input), .perm_start(perm_start),
        .perm_state_output(perm_state_output), .perm_done(perm_done),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
        .busy(busy), .error(error), .block_count(block_count), .dbg_state(dbg_state)
    );

    // Stub permutation: result = input ^ MASK, done pulse stub_delay cycles after perm_start.
    int   stub_cnt = 0;
    int   stub_delay;
    logic stub_enable;
    logic stub_noise;

    always @(negedge clk) begin
        perm_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0 && stub_enable) perm_done = 1'b1;
        end else if (stub_noise && $urandom_range(0, 5) == 0) begin
            perm_done = 1'b1;
            for (int i = 0; i < 16; i++) perm_state_output[i] = $urandom;
        end
        if (perm_start) begin
            stub_cnt = stub_delay;
            for (int i = 0; i < 16; i++) perm_state_output[i] = perm_state_input[i] ^ MASK;
        end
    end

    typedef struct {
        logic [255:0] data;
        logic [255:0] exp_digest;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           ps_viol = 0;
    logic         prev_ps = 1'b0;
    logic [511:0] obs_perm_q[$];
    logic [255:0] msg[8];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return block_ready | perm_start | digest_valid | busy | error | (|perm_state_input) |
               (|digest) | (|block_count) | (|dbg_state);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (perm_start) begin
            obs_perm_q.push_back(perm_state_input);
            if (prev_ps) ps_viol++;
        end
        prev_ps = perm_start;
    endtask

    // Offers a block and returns just after the accepting edge; block_valid stays high.
    task automatic send_block(input logic [255:0] data, input logic last);
        int w = 0;
        block_valid = 1'b1;
        block_data  = data;
        block_last  = last;
        while (!block_ready && w < 300) begin
            tick();
            w++;
        end
        check("block_accept", 512'(block_ready), 512'(1'b1));
        tick();
    endtask

    task automatic finish_digest(input logic [255:0] exp_dig, input int exp_cnt,
                                 input int ready_delay, output logic [255:0] got);
        int           w = 0;
        int           unstable = 0;
        logic [255:0] snap;
        digest_ready = 1'b0;
        while (!digest_valid && w < 300) begin
            tick();
            w++;
        end
        check("digest_valid", 512'(digest_valid), 512'(1'b1));
        snap = digest;
        for (int k = 0; k < ready_delay; k++) begin
            tick();
            if (digest !== snap || block_ready !== 1'b0 || digest_valid !== 1'b1) unstable++;
        end
        got = digest;
        check("digest_hold", 512'(unstable), '0);
        check("digest_value", 512'(digest), 512'(exp_dig));
        check("block_count", 512'(block_count), 512'(exp_cnt));
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check("post_digest_valid", 512'(digest_valid), '0);
        check("post_block_count", 512'(block_count), '0);
        check("post_state", 512'(perm_state_input), '0);
        check("post_block_ready", 512'(block_ready), 512'(1'b1));
    endtask

    // Sponge model over msg[0..n-1]: absorb into words 0..7, permute all 16 words with the mask.
    task automatic run_msg(input int n, input int gap_max, input int ready_delay,
                           output logic [255:0] got);
        logic [31:0]  m[16];
        logic [511:0] exp_q[$];
        logic [511:0] v;
        logic [255:0] dig;
        int           gap;
        for (int i = 0; i < 16; i++) m[i] = '0;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 8; w++) m[w] = m[w] ^ msg[b][255 - 32*w -: 32];
            for (int i = 0; i < 16; i++) v[32*i +: 32] = m[i];
            exp_q.push_back(v);
            for (int i = 0; i < 16; i++) m[i] = m[i] ^ MASK;
        end
        for (int w = 0; w < 8; w++) dig[255 - 32*w -: 32] = m[w];
        obs_perm_q.delete();
        for (int b = 0; b < n; b++) begin
            gap = $urandom_range(0, gap_max);
            repeat (gap) tick();
            send_block(msg[b], b == n - 1);
            block_valid = 1'b0;
            block_data  = rnd256();
            block_last  = 1'($urandom_range(0, 1));
        end
        finish_digest(dig, n, ready_delay, got);
        check("perm_count", 512'(obs_perm_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check("perm_input", (i < obs_perm_q.size()) ? obs_perm_q[i] : '0, exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         vecs[6];
        logic [255:0] got;
        logic [511:0] v;
        int           k;
        int           lows;

        vecs[0] = '{256'h0, {8{32'hA5A5A5A5}}};
        vecs[1] = '{{8{32'hFFFFFFFF}}, {8{32'h5A5A5A5A}}};
        vecs[2] = '{{8{32'hA5A5A5A5}}, 256'h0};
        vecs[3] = '{256'h1, {{7{32'hA5A5A5A5}}, 32'hA5A5A5A4}};
        vecs[4] = '{{32'h5A5A5A5A, 224'h0}, {32'hFFFFFFFF, {7{32'hA5A5A5A5}}}};
        vecs[5] = '{{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h00210A06, 128'h0},
                    {32'hEDC0C9C9, 32'hCA8985D2, 32'hCAD7C9C1, 32'hA584AFA3, {4{32'hA5A5A5A5}}}};

        reset_n = 1'b0; abort = 1'b0; block_valid = 1'b0; block_data = '0;
        block_last = 1'b0; digest_ready = 1'b0;
        stub_enable = 1'b1; stub_delay = 5; stub_noise = 1'b0;

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 6; i++) begin
            tick();
            block_valid  = 1'($urandom_range(0, 1));
            abort        = 1'($urandom_range(0, 1));
            digest_ready = 1'($urandom_range(0, 1));
            block_last   = 1'($urandom_range(0, 1));
            block_data   = rnd256();
            #1;
            check("reset_outputs", 512'(any_out()), '0);
        end
        block_valid = 1'b0; abort = 1'b0; digest_ready = 1'b0; block_last = 1'b0;
        reset_n = 1'b1;
        check("ready_at_release", 512'(block_ready), '0);
        tick();
        check("ready_after_release", 512'(block_ready), 512'(1'b1));
        check("busy_after_release", 512'(busy), '0);

        // Single "Hello, world" block.
        msg[0] = vecs[5].data;
        run_msg(1, 0, 0, got);
        check("t2_perm_input", (obs_perm_q.size() > 0) ? obs_perm_q[0] : '0,
              {384'h0, 32'h00210A06, 32'h6F726C64, 32'h6F2C2077, 32'h48656C6C});
        check("t2_digest_w0", 512'(got[255:224]), 512'(32'hEDC0C9C9));
        check("t2_digest_w4", 512'(got[127:96]), 512'(32'hA5A5A5A5));

        for (int i = 0; i < 6; i++) begin
            msg[0] = vecs[i].data;
            run_msg(1, 2, $urandom_range(0, 3), got);
            check("vec_digest", 512'(got), 512'(vecs[i].exp_digest));
        end

        // Two zero blocks with block_valid held high across the permutation.
        obs_perm_q.delete();
        send_block(256'h0, 1'b0);
        block_last = 1'b1;
        lows = 0;
        while (!block_ready && lows < 300) begin
            lows++;
            tick();
        end
        check("t3_ready_low_cycles", 512'(lows), 512'(6));
        send_block(256'h0, 1'b1);
        block_valid = 1'b0;
        finish_digest(256'h0, 2, 0, got);
        v = (obs_perm_q.size() > 1) ? obs_perm_q[1] : '0;
        check("t3_perm2_w0", 512'(v[31:0]), 512'(MASK));
        check("t3_perm2_w8", 512'(v[287:256]), 512'(MASK));

        // Digest consumer stalls for 10 cycles.
        msg[0] = rnd256();
        msg[1] = rnd256();
        run_msg(2, 1, 10, got);

        // Permutation never answers: timeout, then abort.
        stub_enable = 1'b0;
        send_block(rnd256(), 1'b1);
        block_valid = 1'b0;
        check("t4_perm_start", 512'(perm_start), 512'(1'b1));
        k = 0;
        while (!error && k < 200) begin
            tick();
            k++;
        end
        check("t4_timeout_cycles", 512'(k), 512'(PERM_TIMEOUT));
        check("t4_block_ready", 512'(block_ready), '0);
        check("t4_busy", 512'(busy), 512'(1'b1));
        repeat (3) tick();
        check("t4_error_sticky", 512'(error), 512'(1'b1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_error", 512'(error), '0);
        check("t4_abort_ready", 512'(block_ready), 512'(1'b1));
        check("t4_abort_busy", 512'(busy), '0);
        check("t4_abort_state", 512'(perm_state_input), '0);
        check("t4_abort_count", 512'(block_count), '0);
        stub_enable = 1'b1;

        // Done on the very cycle the timer expires wins.
        stub_delay = PERM_TIMEOUT - 1;
        msg[0] = rnd256();
        run_msg(1, 0, 0, got);
        check("t4_done_at_limit_error", 512'(error), '0);

        // Done one cycle too late: error, and the late done is ignored.
        stub_delay = PERM_TIMEOUT;
        send_block(rnd256(), 1'b1);
        block_valid = 1'b0;
        k = 0;
        while (!error && k < 200) begin
            tick();
            k++;
        end
        check("t4_late_timeout_cycles", 512'(k), 512'(PERM_TIMEOUT));
        repeat (4) tick();
        check("t4_late_done_ignored", 512'({error, digest_valid, busy}), 512'(3'b101));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        stub_delay = 5;

        // Async reset in PERM_WAIT, then the stub's perm_done arrives after release.
        send_block(rnd256(), 1'b1);
        block_valid = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_reset", 512'(any_out()), '0);
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("t6_after_busy", 512'(busy), '0);
        check("t6_after_valid", 512'(digest_valid), '0);
        check("t6_after_state", 512'(perm_state_input), '0);
        check("t6_after_ready", 512'(block_ready), 512'(1'b1));

        // Abort in PERM_WAIT, late perm_done ignored.
        send_block(rnd256(), 1'b0);
        block_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait_busy", 512'(busy), '0);
        repeat (8) tick();
        check("abort_wait_late_done", 512'({busy, digest_valid, block_count}), '0);
        check("abort_wait_state", 512'(perm_state_input), '0);

        // Random messages, random permutation latency, spurious done pulses while not waiting.
        stub_noise = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) msg[b] = rnd256();
            stub_delay = $urandom_range(1, 40);
            run_msg(n, 3, $urandom_range(0, 4), got);
        end
        stub_noise = 1'b0;

        check("perm_start_pulse", 512'(ps_viol), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
